// File: rtl/j1_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : j1_debounce_pkg
// Purpose  : Shared constants, debounce action encoding and a clog2 helper
//            for the J1 header input conditioner.
// Revision : 1.0  initial release
// ============================================================================
package j1_debounce_pkg;

  localparam int CLK_HZ                  = 12_000_000;
  localparam int DEBOUNCE_MS_DEFAULT     = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

  // What a single bit's debouncer does on the coming edge.
  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,  // synced level agrees with output: clear count
    ACT_COUNT  = 2'd1,  // disagreement still too short: keep counting
    ACT_ACCEPT = 2'd2   // disagreement long enough: take the new level
  } debounce_act_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage : j1_debounce_pkg
`default_nettype wire

// File: rtl/j1_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : j1_debounce_bit
// Purpose  : One input bit: synchronizer chain, consecutive-disagreement
//            counter, stable output register and one-cycle change pulse.
// Revision : 1.0  initial release
// ============================================================================
module j1_debounce_bit
  import j1_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_changed
);

  localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   changed_q, changed_d;
  logic                   w_sync;
  debounce_act_e          w_act;

  // Next-state: shift the synchronizer and decide count/accept for this edge.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], i_raw};
    w_sync    = sync_q[SYNC_STAGES-1];
    cnt_d     = cnt_q;
    level_d   = level_q;
    changed_d = 1'b0;

    if (w_sync == level_q) begin
      w_act = ACT_IDLE;
    end else if (cnt_q != CNT_LAST) begin
      w_act = ACT_COUNT;
    end else begin
      w_act = ACT_ACCEPT;
    end

    case (w_act)
      ACT_COUNT: begin
        cnt_d = cnt_q + 1'b1;
      end
      ACT_ACCEPT: begin
        cnt_d     = '0;
        level_d   = w_sync;
        changed_d = 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // State registers; reset discards any partial count and the chain contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      changed_q <= changed_d;
    end
  end

  assign o_level   = level_q;
  assign o_changed = changed_q;

endmodule : j1_debounce_bit
`default_nettype wire

// File: rtl/j1_debounce.sv
`default_nettype none
// ============================================================================
// Module   : j1_debounce
// Purpose  : J1 header input conditioner: per-bit synchronize + debounce,
//            change pulses, and a VALID flag after the post-reset settle time.
// Revision : 1.0  initial release
// ============================================================================
module j1_debounce
  import j1_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] CHANGED,
  output logic             VALID
);

  // A bit held from the first post-reset edge is accepted at edge
  // SYNC_STAGES+DEBOUNCE_CYCLES, so VALID rises on that same edge.
  localparam int                  SETTLE_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int                  SETTLE_W      = clog2(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST   = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                valid_q, valid_d;

  generate
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      j1_debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
        .clk       (CLK),
        .rst       (RESET),
        .i_raw     (I[b]),
        .o_level   (O[b]),
        .o_changed (CHANGED[b])
      );
    end
  endgenerate

  // Settle counter saturates at its last value; VALID latches once reached.
  always_comb begin
    settle_d = settle_q;
    if (settle_q != SETTLE_LAST) begin
      settle_d = settle_q + 1'b1;
    end
    valid_d = valid_q | (settle_q == SETTLE_LAST);
  end

  // Settle state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      settle_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      settle_q <= settle_d;
      valid_q  <= valid_d;
    end
  end

  assign VALID = valid_q;

endmodule : j1_debounce
`default_nettype wire

// File: tb/tb_j1_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_j1_debounce
// Purpose  : Self-checking bench for j1_debounce (SYNC_STAGES=2,
//            DEBOUNCE_CYCLES=4): vector table, corner sequences, random run
//            against a history-window reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_j1_debounce;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] I = '0;
  logic [W-1:0] O;
  logic [W-1:0] CHANGED;
  logic         VALID;

  int n_tests = 0;
  int n_fail  = 0;

  j1_debounce #(
    .WIDTH           (W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I       (I),
    .O       (O),
    .CHANGED (CHANGED),
    .VALID   (VALID)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // pipe: input values still in flight through the synchronizer.
  // hist: last DEB synchronized values seen by the debouncer.
  // A bit flips when every one of the last DEB synced samples disagrees.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_o  = '0;
  logic [W-1:0] m_ch = '0;
  logic         m_v  = 1'b0;
  int           m_edges = 0;

  task automatic model_step(input logic rst, input logic [W-1:0] iv);
    logic [W-1:0] sv;
    bit all_diff;
    if (rst) begin
      m_pipe.delete();
      for (int k = 0; k < SYNC; k++) m_pipe.push_back('0);
      m_hist.delete();
      m_o = '0; m_ch = '0; m_v = 1'b0; m_edges = 0;
    end else begin
      sv = m_pipe.pop_front();
      m_pipe.push_back(iv);
      m_hist.push_back(sv);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      m_ch = '0;
      for (int b = 0; b < W; b++) begin
        all_diff = (m_hist.size() == DEB);
        for (int k = 0; k < m_hist.size(); k++)
          if (m_hist[k][b] == m_o[b]) all_diff = 0;
        if (all_diff) begin
          m_o[b]  = ~m_o[b];
          m_ch[b] = 1'b1;
        end
      end
      m_edges++;
      m_v = (m_edges >= LAT);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, take one edge, update model, compare away from the edge.
  task automatic tick(input logic rst, input logic [W-1:0] iv);
    RESET = rst;
    I     = iv;
    @(posedge CLK);
    model_step(rst, iv);
    #1;
    check("model_O", 32'(O), 32'(m_o));
    check("model_CHANGED", 32'(CHANGED), 32'(m_ch));
    check("model_VALID", 32'(VALID), 32'(m_v));
  endtask

  task automatic reset_and_settle();
    tick(1'b1, '0);
    tick(1'b1, '0);
    for (int n = 0; n < LAT; n++) tick(1'b0, '0);
    check("settle_VALID", 32'(VALID), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic [W-1:0] i;
    logic [W-1:0] exp_o;
    logic [W-1:0] exp_ch;
    logic         exp_v;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [W-1:0] seen, oor, iv;
    int rise, fall, pulses;
    logic [W-1:0] lvl;

    // Reset, settle (VALID at 6th edge after release), clean edge on bit 0.
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[8]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    tbl[9]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    tbl[10] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    tbl[11] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    tbl[12] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    tbl[13] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1};
    tbl[14] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1};
    tbl[15] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1};

    for (int k = 0; k < 16; k++) begin
      tick(tbl[k].rst, tbl[k].i);
      check($sformatf("tbl%0d_O", k), 32'(O), 32'(tbl[k].exp_o));
      check($sformatf("tbl%0d_CHANGED", k), 32'(CHANGED), 32'(tbl[k].exp_ch));
      check($sformatf("tbl%0d_VALID", k), 32'(VALID), 32'(tbl[k].exp_v));
    end

    // Glitch: 3-cycle pulse on bit 2 must be rejected.
    reset_and_settle();
    seen = '0; oor = '0;
    for (int n = 1; n <= 13; n++) begin
      tick(1'b0, (n <= 3) ? 4'b0100 : 4'b0000);
      seen |= CHANGED; oor |= O;
    end
    check("glitch3_CHANGED", 32'(seen), 32'd0);
    check("glitch3_O", 32'(oor), 32'd0);

    // 4-cycle pulse: rises at edge 6, falls at edge 10, two pulses.
    rise = 0; fall = 0; pulses = 0;
    for (int n = 1; n <= 16; n++) begin
      tick(1'b0, (n <= 4) ? 4'b0100 : 4'b0000);
      if (CHANGED[2]) pulses++;
      if (O[2] && rise == 0) rise = n;
      if (!O[2] && rise != 0 && fall == 0) fall = n;
    end
    check("pulse4_rise_edge", 32'(rise), 32'd6);
    check("pulse4_fall_edge", 32'(fall), 32'd10);
    check("pulse4_changed_cnt", 32'(pulses), 32'd2);

    // Bounce on bit 1: final rise at n=5, O[1] rises 6 edges later.
    reset_and_settle();
    rise = 0;
    for (int n = 1; n <= 14; n++) begin
      iv = '0;
      iv[1] = (n >= 5) ? 1'b1 : ((n % 2) == 1);
      tick(1'b0, iv);
      if (O[1] && rise == 0) rise = n;
    end
    check("bounce_rise_edge", 32'(rise), 32'd10);

    // Simultaneous flip of all bits; comparator sees equal pairs throughout.
    reset_and_settle();
    for (int n = 1; n <= 8; n++) begin
      tick(1'b0, 4'b1111);
      check("simul_J3", 32'({O[3] ~^ O[1], O[2] ~^ O[0]}), 32'd3);
      if (n == 5) check("simul_O_before", 32'(O), 32'h0);
      if (n == 6) begin
        check("simul_O", 32'(O), 32'hF);
        check("simul_CHANGED", 32'(CHANGED), 32'hF);
      end
      if (n == 7) check("simul_CHANGED_off", 32'(CHANGED), 32'h0);
    end

    // Reset mid-count on bit 3, then re-acquire coincident with VALID.
    reset_and_settle();
    for (int n = 1; n <= 5; n++) tick(1'b0, 4'b1000);
    tick(1'b1, 4'b1000);
    check("rstmid_O", 32'(O), 32'h0);
    check("rstmid_CHANGED", 32'(CHANGED), 32'h0);
    check("rstmid_VALID", 32'(VALID), 32'h0);
    for (int n = 1; n <= 7; n++) begin
      tick(1'b0, 4'b1000);
      if (n < 6) begin
        check("rstmid_O3_early", 32'(O[3]), 32'd0);
        check("rstmid_VALID_early", 32'(VALID), 32'd0);
      end else if (n == 6) begin
        check("rstmid_O3_rise", 32'(O[3]), 32'd1);
        check("rstmid_CH3_rise", 32'(CHANGED[3]), 32'd1);
        check("rstmid_VALID_rise", 32'(VALID), 32'd1);
      end else begin
        check("rstmid_CH3_off", 32'(CHANGED[3]), 32'd0);
      end
    end

    // Random run: bits held for random durations, occasional resets.
    lvl = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) lvl[b] = ~lvl[b];
      tick(($urandom_range(0, 249) == 0), lvl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_j1_debounce
`default_nettype wire
